// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch-queue bus bundling redirect, imem and decode handshakes
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     redirect_i;
  logic [31:0]              redirect_pc_i;
  logic                     imem_req_o;
  logic [31:0]              imem_addr_o;
  logic                     imem_gnt_i;
  logic                     imem_rvalid_i;
  logic [31:0]              imem_rdata_i;
  logic                     instr_valid_o;
  logic [31:0]              instr_o;
  logic [31:0]              instr_pc_o;
  logic                     instr_ready_i;
  logic [$clog2(DEPTH):0]   count_o;
  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
  );
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: credit-limited instruction prefetch queue with redirect flush; IFQ_BYPASS_EN enables empty-queue response bypass
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk_i,
  input logic                 rst_n,
  instr_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          grant, rsp, push, pop, bypass, stored_valid;
  assign grant        = bus.imem_req_o && bus.imem_gnt_i;
  assign rsp          = state == WAIT && bus.imem_rvalid_i;
  assign stored_valid = cnt != '0;
`ifdef IFQ_BYPASS_EN
  assign bypass = rsp && !bus.redirect_i && !stored_valid && bus.instr_ready_i;
`else
  assign bypass = 1'b0;
`endif
  assign push         = rsp && !bus.redirect_i && !bypass;
  assign pop          = stored_valid && bus.instr_ready_i;
  assign cnt_nxt      = bus.redirect_i ? '0 : cnt + CW'(push) - CW'(pop);
  assign fetch_pc_nxt = bus.redirect_i ? (bus.redirect_pc_i & ~32'd3) : grant ? fetch_pc + 32'd4 : fetch_pc;
  assign bus.imem_req_o    = state == REQ;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = stored_valid || bypass;
  assign bus.instr_o       = bypass ? bus.imem_rdata_i : stored_valid ? data_q[rptr] : '0;
  assign bus.instr_pc_o    = bypass ? fetch_pc - 32'd4 : stored_valid ? pc_q[rptr] : '0;
  assign bus.count_o       = cnt;
  // fetch sequencing: one outstanding request, credit checked before each new request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (bus.redirect_i || cnt != FULL) ? REQ : IDLE;
      REQ:     state_nxt = grant ? (bus.redirect_i ? DROP : WAIT) : REQ;
      WAIT:    state_nxt = bus.imem_rvalid_i ? (cnt_nxt != FULL ? REQ : IDLE) : bus.redirect_i ? DROP : WAIT;
      DROP:    state_nxt = bus.imem_rvalid_i ? REQ : DROP;
      default: state_nxt = IDLE;
    endcase
  end
  // state, fetch address and queue pointers; redirect flushes the queue
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rptr     <= '0;
      wptr     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      cnt      <= cnt_nxt;
      rptr     <= bus.redirect_i ? '0 : rptr + AW'(pop);
      wptr     <= bus.redirect_i ? '0 : wptr + AW'(push);
    end
  end
  // queue storage; the in-flight word's address is one step behind fetch_pc
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wptr] <= bus.imem_rdata_i;
      pc_q[wptr]   <= fetch_pc - 32'd4;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed tests for instr_fetch_queue
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int dly = 0;
  int lat = 1;
  logic [31:0] paddr = '0;
  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus();
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h2002_0005;
  endfunction

  task automatic tick();
    logic granted;
    logic [31:0] a;
    granted = bus.imem_req_o === 1'b1 && bus.imem_gnt_i === 1'b1;
    a = bus.imem_addr_o;
    @(posedge clk);
    #1;
    if (!rst_n) dly = 0;
    else begin
      if (dly > 0) dly--;
      if (granted) begin
        dly = lat;
        paddr = a;
      end
    end
    bus.imem_rvalid_i = dly == 1;
    bus.imem_rdata_i = dly == 1 ? img(paddr) : 32'h0;
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = pc;
    tick();
    bus.redirect_i = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_o === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o); end
    total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.imem_req_o); end
    total++; if (bus.instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
    total++; if (bus.instr_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.instr_pc_o); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc = 32'h0;
    int n = 0;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (bus.instr_valid_o === 1'b1) begin
        total++;
        if (bus.instr_pc_o !== exp_pc || bus.instr_o !== img(exp_pc)) begin bad++; $display("FAIL stream_pop: got pc=%h instr=%h want pc=%h instr=%h", bus.instr_pc_o, bus.instr_o, exp_pc, img(exp_pc)); end
        exp_pc += 32'd4;
        n++;
      end
      tick();
    end
    total++; if (n < 10) begin bad++; $display("FAIL stream_rate: got %0d pops want >=10", n); end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc = 32'h0;
    int n = 0;
    bit seen = 0;
    bus.instr_ready_i = 1'b0;
    redirect_to(32'h0);
    for (int i = 0; i < 40 && bus.count_o !== 3'd4; i++) tick();
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", bus.count_o); end
    total++; if (bus.instr_pc_o !== 32'h0 || bus.instr_o !== 32'h2002_0005) begin bad++; $display("FAIL full_head: got pc=%h instr=%h want pc=0 instr=20020005", bus.instr_pc_o, bus.instr_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.imem_req_o !== 1'b0 || bus.count_o !== 3'd4 || bus.instr_o !== 32'h2002_0005 || bus.instr_pc_o !== 32'h0) begin bad++; $display("FAIL full_hold: got req=%b count=%0d pc=%h instr=%h want req=0 count=4 pc=0 instr=20020005", bus.imem_req_o, bus.count_o, bus.instr_pc_o, bus.instr_o); end
    end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_valid_o === 1'b1) begin
        total++;
        if (bus.instr_pc_o !== exp_pc || bus.instr_o !== img(exp_pc)) begin bad++; $display("FAIL drain_pop: got pc=%h instr=%h want pc=%h", bus.instr_pc_o, bus.instr_o, exp_pc); end
        exp_pc += 32'd4;
        n++;
      end
      if (bus.imem_req_o === 1'b1 && !seen) begin
        seen = 1;
        total++; if (bus.imem_addr_o !== 32'h10) begin bad++; $display("FAIL resume_addr: got %h want 00000010", bus.imem_addr_o); end
      end
      tick();
    end
    total++; if (n < 4 || !seen) begin bad++; $display("FAIL drain_progress: got pops=%0d resumed=%0d want pops>=4 resumed=1", n, seen); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit seen = 0;
    bit got = 0;
    bus.instr_ready_i = 1'b1;
    lat = 2;
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL rw_req: got no request want request"); end
    tick();
    redirect_to(32'h0000_0103);
    total++; if (bus.count_o !== 3'd0 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL rw_flush: got count=%0d valid=%b want 0 0", bus.count_o, bus.instr_valid_o); end
    for (int i = 0; i < 15 && !got; i++) begin
      if (bus.imem_req_o === 1'b1 && !seen) begin
        seen = 1;
        total++; if (bus.imem_addr_o !== 32'h100) begin bad++; $display("FAIL rw_addr: got %h want 00000100", bus.imem_addr_o); end
      end
      if (bus.instr_valid_o === 1'b1) begin
        got = 1;
        total++; if (bus.instr_pc_o !== 32'h100 || bus.instr_o !== 32'h2002_0105) begin bad++; $display("FAIL rw_first: got pc=%h instr=%h want pc=00000100 instr=20020105", bus.instr_pc_o, bus.instr_o); end
      end else tick();
    end
    total++; if (!got) begin bad++; $display("FAIL rw_timeout: got no instruction want one"); end
    lat = 1;
  endtask

  task automatic test_redirect_pop_push();
    bit got = 0;
    bus.instr_ready_i = 1'b0;
    redirect_to(32'h200);
    for (int i = 0; i < 30 && !(bus.count_o === 3'd2 && bus.imem_rvalid_i === 1'b1); i++) tick();
    total++; if (bus.count_o !== 3'd2 || bus.imem_rvalid_i !== 1'b1) begin bad++; $display("FAIL rpp_setup: got count=%0d rvalid=%b want 2 1", bus.count_o, bus.imem_rvalid_i); end
    bus.instr_ready_i = 1'b1;
    redirect_to(32'h300);
    total++; if (bus.count_o !== 3'd0 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL rpp_flush: got count=%0d valid=%b want 0 0", bus.count_o, bus.instr_valid_o); end
    total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h300) begin bad++; $display("FAIL rpp_addr: got req=%b addr=%h want 1 00000300", bus.imem_req_o, bus.imem_addr_o); end
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.instr_valid_o === 1'b1) got = 1;
      else tick();
    end
    total++; if (!got || bus.instr_pc_o !== 32'h300 || bus.instr_o !== 32'h2002_0305) begin bad++; $display("FAIL rpp_first: got pc=%h instr=%h want pc=00000300 instr=20020305", bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_gnt_stall();
    bit ok;
    bit got = 0;
    bus.imem_gnt_i = 1'b0;
    redirect_to(32'h400);
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL gs_req: got no request want request"); end
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== (c <= 3 ? 32'h400 : 32'h504)) begin bad++; $display("FAIL gs_addr%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req_o, bus.imem_addr_o, c <= 3 ? 32'h400 : 32'h504); end
      if (c == 3) redirect_to(32'h507);
      else tick();
    end
    bus.imem_gnt_i = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.instr_valid_o === 1'b1) got = 1;
      else tick();
    end
    total++; if (!got || bus.instr_pc_o !== 32'h504 || bus.instr_o !== 32'h2002_0501) begin bad++; $display("FAIL gs_first: got pc=%h instr=%h want pc=00000504 instr=20020501", bus.instr_pc_o, bus.instr_o); end
  endtask

  task automatic test_bypass();
    bit ok;
    bus.instr_ready_i = 1'b1;
    redirect_to(32'h0);
    wait_req(ok);
    total++; if (!ok || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL bp_req: got ok=%0d addr=%h want 1 0", ok, bus.imem_addr_o); end
    tick();
`ifdef IFQ_BYPASS_EN
    total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h2002_0005 || bus.instr_pc_o !== 32'h0) begin bad++; $display("FAIL bp_same: got valid=%b instr=%h pc=%h want 1 20020005 0", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o); end
    tick();
    total++; if (bus.count_o !== 3'd0 || bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL bp_unstored: got count=%0d valid=%b want 0 0", bus.count_o, bus.instr_valid_o); end
`else
    total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL bp_same: got valid=%b want 0", bus.instr_valid_o); end
    tick();
    total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h2002_0005 || bus.instr_pc_o !== 32'h0) begin bad++; $display("FAIL bp_next: got valid=%b instr=%h pc=%h want 1 20020005 0", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat = 2;
    wait_req(ok);
    total++; if (!ok) begin bad++; $display("FAIL rm_req: got no request want request"); end
    tick();
    rst_n = 1'b0;
    tick();
    total++; if (bus.count_o !== 3'd0 || bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.instr_o !== 32'h0) begin bad++; $display("FAIL rm_state: got count=%0d valid=%b req=%b instr=%h want 0 0 0 0", bus.count_o, bus.instr_valid_o, bus.imem_req_o, bus.instr_o); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin bad++; $display("FAIL rm_restart: got req=%b addr=%h want 1 0", bus.imem_req_o, bus.imem_addr_o); end
    lat = 1;
  endtask

  initial begin
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    bus.instr_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_pop_push();
    test_gnt_stall();
    test_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 redirect_i  input  1  SHALL request a flush and refetch from redirect_pc_i (branch/jump/jr resolved downstream).
REQ-006 redirect_pc_i  input  32  SHALL give the new fetch address; bits [1:0] are ignored and treated as 00.
REQ-007 imem_req_o  output  1  SHALL flag a fetch request.
REQ-008 imem_addr_o  output  32  SHALL give the fetch address, word aligned.
REQ-009 imem_gnt_i  input  1  SHALL mark request acceptance; the handshake completes when imem_req_o & imem_gnt_i.
REQ-010 imem_rvalid_i  input  1  SHALL mark response data valid, one response per granted request, in order, at least 1 cycle after the grant.
REQ-011 imem_rdata_i  input  32  SHALL carry the response instruction word.
REQ-012 instr_valid_o  output  1  SHALL flag that instr_o/instr_pc_o hold a valid entry.
REQ-013 instr_o  output  32  SHALL give the oldest queued instruction.
REQ-014 instr_pc_o  output  32  SHALL give the address of instr_o.
REQ-015 instr_ready_i  input  1  SHALL mark consumption by the decode stage; a pop occurs when instr_valid_o & instr_ready_i.
REQ-016 count_o  output  $clog2(DEPTH)+1  SHALL give the current queue occupancy.

Function
REQ-017 Fetch FSM states SHALL be IDLE, REQ, WAIT and DROP, with at most one granted request outstanding.
REQ-018 IDLE->REQ SHALL occur when occupancy + outstanding < DEPTH; otherwise the FSM stays in IDLE.
REQ-019 In REQ, imem_req_o=1 with imem_addr_o=fetch_pc held stable until grant; on grant fetch_pc += 4 (mod 2^32 wrap) and go WAIT.
REQ-020 In WAIT, on imem_rvalid_i push {imem_rdata_i, pc} and go to REQ if credit remains, else IDLE.
REQ-021 Push and pop in the same cycle SHALL both occur; count_o stays unchanged.
REQ-022 A pop when empty or a push when full SHALL never happen; the credit rule in REQ-018 guarantees no push when full.
REQ-023 instr_o/instr_pc_o SHALL stay stable while instr_valid_o=1 and instr_ready_i=0.
REQ-024 On redirect_i, the queue SHALL be emptied next cycle, count_o=0, instr_valid_o=0, and fetch_pc=redirect_pc_i&~3.
REQ-025 Redirect in IDLE or in REQ without same-cycle grant SHALL go to REQ at the new PC; any ungranted request is abandoned.
REQ-026 Redirect in REQ with same-cycle grant, or in WAIT without same-cycle rvalid, SHALL go to DROP.
REQ-027 Redirect in WAIT with same-cycle rvalid SHALL discard that data and go to REQ.
REQ-028 DROP SHALL hold imem_req_o=0, discard the next rvalid and then go to REQ; a redirect in DROP updates fetch_pc and stays in DROP.
REQ-029 Redirect SHALL take priority over a same-cycle pop or push; no instruction from the old stream is ever presented after redirect_i.

Reset
REQ-030 With rst_n=0 at a clock edge, next state SHALL be: FSM=IDLE, fetch_pc=RESET_PC, queue empty, count_o=0, instr_valid_o=0, imem_req_o=0, instr_o=0, instr_pc_o=0.
REQ-031 Reset asserted mid-transaction SHALL abandon any outstanding response; the memory model is reset on the same rst_n.
REQ-032 The first request SHALL issue in the first cycle after rst_n rises, at RESET_PC.

Configuration
REQ-033 With macro IFQ_BYPASS_EN defined, a response arriving while the queue is empty and instr_ready_i=1 SHALL appear combinationally on instr_o/instr_valid_o in the same cycle and not be stored.
REQ-034 Without IFQ_BYPASS_EN, every response SHALL be stored first and become visible on instr_valid_o the cycle after rvalid; all other behaviour is identical.

Verification
REQ-035 Reset, then memory with gnt=1 always and rvalid 1 cycle later, ready=1 -> instr_pc_o sequence 0x0,0x4,0x8,... with words matching the memory image.
REQ-036 ready=0 with DEPTH=4 -> count_o reaches 4, imem_req_o stays 0, instr_o stable; then ready=1 -> 4 pops in order and fetch resumes at 0x10.
REQ-037 Redirect to 0x0000_0103 while in WAIT -> in-flight word dropped, next presented instr_pc_o=0x0000_0100, no stale entry seen.
REQ-038 Redirect in the same cycle as a pop and a push with count_o=2 -> count_o=0 next cycle, next fetch at the redirect PC.
REQ-039 gnt held low for 5 cycles -> imem_addr_o constant throughout; redirect on cycle 3 -> imem_addr_o switches to the new PC next cycle.
REQ-040 With IFQ_BYPASS_EN, empty queue, ready=1, rvalid carrying 0x2002_0005 -> instr_valid_o=1 and instr_o=0x2002_0005 in the rvalid cycle; without the macro, they appear one cycle later.
